// File: rtl/nf_sbox_compress_stage.sv
// Register stage after the NullFresh coordinate functions: captures all coordinate
// outputs, XOR-compresses them into three shares per S-box output bit, and registers the shares.
module nf_sbox_compress_stage #(
   parameter int unsigned NUM_NIBBLES = 16,
   parameter int unsigned CF_PER_BIT  = 18,
   localparam int unsigned CF_W       = 4 * CF_PER_BIT * NUM_NIBBLES
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [CF_W-1:0]            cf_in,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [4*NUM_NIBBLES-1:0]   q1,
   output logic [4*NUM_NIBBLES-1:0]   q2,
   output logic [4*NUM_NIBBLES-1:0]   q3,
   output logic                       busy
);

   localparam int unsigned NB = 4 * NUM_NIBBLES;
   localparam int unsigned G  = CF_PER_BIT / 3;

   logic [CF_W-1:0] cf_q, cf_d;
   logic            s1_valid_q, s1_valid_d;
   logic [NB-1:0]   q1_q, q1_d;
   logic [NB-1:0]   q2_q, q2_d;
   logic [NB-1:0]   q3_q, q3_d;
   logic            out_valid_q, out_valid_d;

   logic [NB-1:0]   q1_c, q2_c, q3_c;
   logic            s1_load;
   logic            s2_load;

   assign in_ready  = rst_n && (!s1_valid_q || !out_valid_q || out_ready);
   assign s1_load   = in_valid && in_ready;
   assign s2_load   = s1_valid_q && (!out_valid_q || out_ready);

   assign out_valid = out_valid_q;
   assign busy      = s1_valid_q || out_valid_q;
   assign q1        = q1_q;
   assign q2        = q2_q;
   assign q3        = q3_q;

   // Compression reads only cf_q, so cf_in glitches never propagate into the share registers.
   always_comb begin
      q1_c = '0;
      q2_c = '0;
      q3_c = '0;
      for (int unsigned j = 0; j < NB; j++) begin
         for (int unsigned k = 0; k < G; k++) begin
            q1_c[j] = q1_c[j] ^ cf_q[j*CF_PER_BIT + k];
            q2_c[j] = q2_c[j] ^ cf_q[j*CF_PER_BIT + G + k];
            q3_c[j] = q3_c[j] ^ cf_q[j*CF_PER_BIT + 2*G + k];
         end
      end
   end

   always_comb begin
      cf_d        = cf_q;
      s1_valid_d  = s1_valid_q;
      q1_d        = q1_q;
      q2_d        = q2_q;
      q3_d        = q3_q;
      out_valid_d = out_valid_q;
      if (flush) begin
         cf_d        = '0;
         s1_valid_d  = 1'b0;
         q1_d        = '0;
         q2_d        = '0;
         q3_d        = '0;
         out_valid_d = 1'b0;
      end else begin
         if (s2_load) begin
            q1_d        = q1_c;
            q2_d        = q2_c;
            q3_d        = q3_c;
            out_valid_d = 1'b1;
         end else if (out_ready) begin
            out_valid_d = 1'b0;
         end
         if (s1_load) begin
            cf_d       = cf_in;
            s1_valid_d = 1'b1;
         end else if (s2_load) begin
            s1_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cf_q        <= '0;
         s1_valid_q  <= 1'b0;
         q1_q        <= '0;
         q2_q        <= '0;
         q3_q        <= '0;
         out_valid_q <= 1'b0;
      end else begin
         cf_q        <= cf_d;
         s1_valid_q  <= s1_valid_d;
         q1_q        <= q1_d;
         q2_q        <= q2_d;
         q3_q        <= q3_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule
